// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared pipeline constants (MDU state encodings, register-index width, zero register)
package cpu_pipe_pkg;
   localparam int REG_AW = 5;
   localparam logic [4:0] REG_ZERO = 5'd0;
   typedef enum logic {HZ_IDLE = 1'b0, HZ_BUSY = 1'b1} hz_state_e;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID decode / ID-EX inputs and pipeline-register controls of the hazard controller
//  master: pipeline side (drives decode/EX info, receives controls)
//  slave:  hazard_ctrl side
interface hazard_ctrl_if #(parameter int AW = cpu_pipe_pkg::REG_AW);
   logic [AW-1:0] id_rs, id_rt, ex_rd;
   logic id_use_rs, id_use_rt, id_uses_hilo, ex_mem_read, ex_mdu_start, ex_redirect;
   logic pc_wr, if_id_wr, if_id_flush, id_ex_stall, id_ex_flush, mdu_busy;
   modport master (
      output id_rs, id_rt, ex_rd, id_use_rs, id_use_rt, id_uses_hilo, ex_mem_read, ex_mdu_start, ex_redirect,
      input  pc_wr, if_id_wr, if_id_flush, id_ex_stall, id_ex_flush, mdu_busy
   );
   modport slave (
      input  id_rs, id_rt, ex_rd, id_use_rs, id_use_rt, id_uses_hilo, ex_mem_read, ex_mdu_start, ex_redirect,
      output pc_wr, if_id_wr, if_id_flush, id_ex_stall, id_ex_flush, mdu_busy
   );
endinterface

// File: rtl/hazard_ctrl_mdu_busy_tracker.sv
// mdu_busy_tracker: MUL/DIV busy FSM; busy is high for MDU_LAT cycles after a start
//  ports: clk, rst (async active-low), start in, busy out
module mdu_busy_tracker import cpu_pipe_pkg::*; #(
   parameter int MDU_LAT = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic busy
);
   localparam int CW = $clog2(MDU_LAT + 1);
   hz_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q <= HZ_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   // a start reloads the counter even when already busy (restart after a flushed MDU op)
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (start) begin
         state_d = HZ_BUSY;
         cnt_d   = CW'(MDU_LAT);
      end else if (state_q == HZ_BUSY) begin
         cnt_d   = cnt_q - CW'(1);
         state_d = (cnt_q == CW'(1)) ? HZ_IDLE : HZ_BUSY;
      end
   end
   assign busy = (state_q == HZ_BUSY);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / HI-LO stall and redirect flush control for PC, IF/ID, ID/EX
//  ports: clk, rst (async active-low), bus (hazard_ctrl_if.slave),
//         perf_stalls/perf_flushes when HAZ_PERF_EN is defined
module hazard_ctrl #(
   parameter int MDU_LAT = 32,
   parameter int REG_AW  = cpu_pipe_pkg::REG_AW,
   parameter int PERF_W  = 32
) (
   input  logic clk,
   input  logic rst,
   hazard_ctrl_if.slave bus
`ifdef HAZ_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_stalls,
   output logic [PERF_W-1:0] perf_flushes
`endif
);
   import cpu_pipe_pkg::*;
   logic busy, load_use, hilo_stall, stall;
   mdu_busy_tracker #(.MDU_LAT(MDU_LAT)) u_mdu (.clk(clk), .rst(rst), .start(bus.ex_mdu_start), .busy(busy));
   assign load_use = bus.ex_mem_read & (bus.ex_rd != REG_AW'(REG_ZERO)) &
                     ((bus.id_use_rs & (bus.id_rs == bus.ex_rd)) | (bus.id_use_rt & (bus.id_rt == bus.ex_rd)));
   assign hilo_stall = busy & bus.id_uses_hilo;
   // the stalling ID instruction is squashed by a redirect, so no stall is needed
   assign stall = (load_use | hilo_stall) & ~bus.ex_redirect;
   // while in reset the pipeline is frozen and both pipeline registers are cleared
   assign bus.pc_wr       = rst & ~stall;
   assign bus.if_id_wr    = rst & ~stall;
   assign bus.id_ex_stall = rst & stall;
   assign bus.if_id_flush = ~rst | bus.ex_redirect;
   assign bus.id_ex_flush = ~rst | bus.ex_redirect;
   assign bus.mdu_busy    = rst & busy;
`ifdef HAZ_PERF_EN
   logic [PERF_W-1:0] stalls_q, stalls_d, flushes_q, flushes_d;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         stalls_q  <= '0;
         flushes_q <= '0;
      end else begin
         stalls_q  <= stalls_d;
         flushes_q <= flushes_d;
      end
   always_comb begin
      stalls_d  = stall ? stalls_q + PERF_W'(1) : stalls_q;
      flushes_d = bus.ex_redirect ? flushes_q + PERF_W'(1) : flushes_q;
   end
   assign perf_stalls  = stalls_q;
   assign perf_flushes = flushes_q;
`endif
   a_start_redirect: assert property (@(posedge clk) disable iff (!rst) !(bus.ex_mdu_start && bus.ex_redirect))
      else $error("ex_mdu_start and ex_redirect asserted together");
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl (MDU_LAT=4)
module tb_hazard_ctrl;
   logic clk = 0, rst = 0;
   always #5 clk = ~clk;
   hazard_ctrl_if #(.AW(5)) bus ();
`ifdef HAZ_PERF_EN
   logic [31:0] perf_stalls, perf_flushes;
`endif
   hazard_ctrl #(.MDU_LAT(4), .REG_AW(5), .PERF_W(32)) dut (
      .clk(clk), .rst(rst), .bus(bus)
`ifdef HAZ_PERF_EN
      , .perf_stalls(perf_stalls), .perf_flushes(perf_flushes)
`endif
   );
   typedef struct { string name; logic [5:0] exp; bit chk_perf; int ps; int pf; } exp_t;
   exp_t q[$];
   exp_t e;
   logic [5:0] act;
   int pass_cnt = 0, total = 0;
   // expected vector order: {pc_wr, if_id_wr, if_id_flush, id_ex_stall, id_ex_flush, mdu_busy}
   localparam logic [5:0] RST = 6'b001010, RUN = 6'b110000, STL = 6'b000100,
                          RDR = 6'b111010, BSY = 6'b110001, HST = 6'b000101;
   always @(negedge clk)
      while (q.size() > 0) begin
         e = q.pop_front();
         act = {bus.pc_wr, bus.if_id_wr, bus.if_id_flush, bus.id_ex_stall, bus.id_ex_flush, bus.mdu_busy};
         total++;
         if (act === e.exp) pass_cnt++;
         else $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
`ifdef HAZ_PERF_EN
         if (e.chk_perf) begin
            total++;
            if (perf_stalls == 32'(e.ps) && perf_flushes == 32'(e.pf)) pass_cnt++;
            else $display("FAIL %s perf: got stalls=%0d flushes=%0d expected %0d/%0d",
                          e.name, perf_stalls, perf_flushes, e.ps, e.pf);
         end
`endif
      end
   task automatic cyc(input string n, input logic [5:0] x);
      q.push_back('{n, x, 1'b0, 0, 0});
      @(posedge clk); #1;
   endtask
   task automatic cyc_perf(input string n, input logic [5:0] x, input int ps, input int pf);
      q.push_back('{n, x, 1'b1, ps, pf});
      @(posedge clk); #1;
   endtask
   task automatic clr();
      bus.id_rs = '0; bus.id_rt = '0; bus.ex_rd = '0;
      bus.id_use_rs = 0; bus.id_use_rt = 0; bus.id_uses_hilo = 0;
      bus.ex_mem_read = 0; bus.ex_mdu_start = 0; bus.ex_redirect = 0;
   endtask
   initial begin
      clr();
      @(posedge clk); #1;
      cyc("reset0", RST);
      cyc("reset1", RST);
      rst = 1;
      cyc("idle", RUN);
      bus.ex_mem_read = 1; bus.ex_rd = 8; bus.id_use_rs = 1; bus.id_rs = 8;
      cyc("lu_rs", STL);
      bus.ex_rd = 0; bus.id_rs = 0;
      cyc("lu_rd0", RUN);
      bus.id_use_rs = 0; bus.id_use_rt = 1; bus.id_rt = 9; bus.ex_rd = 9;
      cyc("lu_rt", STL);
      bus.id_use_rt = 0;
      cyc("no_use_rt", RUN);
      bus.id_use_rt = 1; bus.ex_mem_read = 0;
      cyc("no_memread", RUN);
      bus.id_rt = 10; bus.ex_mem_read = 1;
      cyc("lu_mismatch", RUN);
      bus.id_rt = 9; bus.ex_redirect = 1;
      cyc("lu_redirect", RDR);
      clr();
      bus.ex_mdu_start = 1;
      cyc("mdu_start", RUN);
      bus.ex_mdu_start = 0; bus.id_uses_hilo = 1;
      for (int i = 1; i <= 4; i++) cyc($sformatf("hilo_busy%0d", i), HST);
      cyc("hilo_done", RUN);
      bus.id_uses_hilo = 0; bus.ex_mdu_start = 1;
      cyc("mdu_start2", RUN);
      cyc("mdu_reload", BSY);
      bus.ex_mdu_start = 0; bus.id_uses_hilo = 1;
      for (int i = 1; i <= 4; i++) cyc($sformatf("reload_busy%0d", i), HST);
      cyc("reload_done", RUN);
      bus.id_uses_hilo = 0; bus.ex_mdu_start = 1;
      cyc("mdu_start3", RUN);
      bus.ex_mdu_start = 0; bus.id_uses_hilo = 1;
      cyc("rst_busy1", HST);
      rst = 0;
      cyc("rst_mid_busy", RST);
      rst = 1;
      cyc("post_rst_idle", RUN);
      cyc("post_rst_idle2", RUN);
      clr();
`ifdef HAZ_PERF_EN
      rst = 0;
      cyc("perf_reset", RST);
      rst = 1;
      bus.ex_redirect = 1;
      for (int i = 0; i < 3; i++) cyc("perf_redirect", RDR);
      bus.ex_redirect = 0; bus.ex_mem_read = 1; bus.ex_rd = 3; bus.id_use_rs = 1; bus.id_rs = 3;
      for (int i = 0; i < 2; i++) cyc("perf_stall", STL);
      clr();
      cyc_perf("perf_counts", RUN, 2, 3);
`endif
      @(negedge clk); #1;
      if (q.size() != 0) begin
         total++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
